mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
- Shares one registered N-bit multiplier among NREQ dataflow requesters in the operator graph.
- Round-robin grants one requester per cycle when both of its operands are ready; it then pipelines the operation and routes the result back to that requester's output slot.
- Replaces NREQ separate multiplier operators where area matters.
- Operand inputs, result outputs and EN gating keep the same semantics as the standalone multiplier operator.

Parameters:
- N, 16, operand/result width.
- NREQ, 4, number of requesters (2..16).
- IDW, $clog2(NREQ), tag width (derived; do not override).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- EN  in  1  global enable; low = freeze (no grant, pipeline holds).
- R_IN1  in  NREQ  operand-1 ready, one bit per requester; held until acknowledged.
- D_IN1  in  NREQ*N  operand-1 data; requester i occupies bits [i*N +: N].
- R_IN2  in  NREQ  operand-2 ready per requester.
- D_IN2  in  NREQ*N  operand-2 data, packed as D_IN1.
- ACK  out  NREQ  one-hot, combinational; requester i's operands are consumed this cycle.
- R_OUT  out  NREQ  result-valid per requester; one-cycle pulse.
- D_OUT  out  NREQ*N  result per requester; holds its last value.
- BUSY  out  1  some operation is in flight in pipeline stage 1 or 2.

Behaviour:
- **Reset.** RST=1 at a clock edge sets the following, regardless of EN:
  - R_OUT=0, D_OUT=0 (all slots), BUSY=0.
  - Round-robin pointer PTR=0; both stage valids cleared.
  - RST mid-operation discards in-flight work; no R_OUT pulse follows.
- **Eligibility.** Requester i is eligible when R_IN1[i] & R_IN2[i].
- **Arbitration** (combinational, cycle t):
  - If EN=1 and any requester is eligible, grant the first eligible index searching PTR, PTR+1, ..., wrapping modulo NREQ.
  - ACK[granted]=1; all other ACK bits 0. ACK=0 whenever EN=0 or RST=1.
  - A requester whose operands are only partly ready is never granted.
- **Pointer update.** On a grant to g, PTR <= (g+1) mod NREQ. With no grant, PTR holds.
  - Wrap: g=NREQ-1 gives PTR=0.
- **Stage 1** (edge ending cycle t, EN=1):
  - S1_V <= grant.
  - S1_A, S1_B, S1_ID <= granted operands and index.
- **Stage 2** (next edge, EN=1):
  - S2_V <= S1_V; S2_ID <= S1_ID.
  - S2_P <= low N bits of S1_A*S1_B (unsigned, truncated).
  - If S1_B==0, S2_P <= 0 explicitly (zero-operand path).
- **Output.**
  - R_OUT[i] = S2_V & (S2_ID==i), registered.
  - D_OUT slot S2_ID is updated only when S2_V=1; other slots hold.
  - Latency: the ACK cycle is t; R_OUT is high in cycle t+2.
- **Throughput.** One issue per cycle. Back-to-back grants to different requesters are pipelined without bubbles.
  - A requester holding R_IN high after its ACK is re-eligible next cycle, but is granted only after other eligible requesters (fairness).
- **EN=0.** All registers hold, including a pending R_OUT pulse, which stays high until EN returns and the pipeline advances. With EN=0, R_OUT[i] stays high while stalled.
- **BUSY** = S1_V | S2_V.
- **Simultaneous events.** All requesters eligible with PTR=k: grant order is k, k+1, ..., wrapping, one per cycle.

Optional Feature:
- Macro MUL_ARB_STATS_EN.
- Defined:
  - Adds output GRANTS, width NREQ*16: per-requester saturating grant counters, packed [i*16 +: 16].
  - Adds output STALLS, width 16: saturating count of cycles where at least one requester was eligible but ungranted.
  - All counters are cleared by RST and increment only when EN=1.
  - Saturation: a counter at 16'hFFFF holds.
- Undefined: the ports and counters are absent. Core behaviour is identical.

Decomposition:
- Package mul_arb_pkg holds:
  - A width-helper function for IDW.
  - The counter width constant (16).
  - The saturate-increment function.
- One sub-module, rr_arbiter:
  - Inputs: request vector, PTR, EN.
  - Outputs: one-hot grant, grant index, any-grant.
  - Fully combinational; PTR lives in the parent.

Test Plan:
- **Reset mid-flight.** Issue a grant, assert RST in cycle t+1 → no R_OUT pulse; D_OUT=0; BUSY=0; PTR=0.
- **Single requester.** Requester 2 with D_IN1=7, D_IN2=9 → ACK[2] in cycle t; R_OUT[2] pulse in t+2 with D_OUT slot2=63; other slots stay 0.
- **Full contention.** NREQ=4, all eligible continuously, PTR=0 → ACK order 0,1,2,3,0; R_OUT pulses in the same order, 2 cycles later, no bubbles.
- **Wrap and truncation.** PTR=3 with only requesters 3 and 0 eligible → grant 3 then 0. Operands 16'hFFFF*2 → 16'hFFFE.
- **Zero operand and partial readiness.** D_IN2=0 gives D_OUT=0. R_IN1[1]=1 with R_IN2[1]=0 → never ACKed.
- **EN stall.** EN=0 for 3 cycles with S1_V=1 → no ACK; pipeline frozen. When EN returns, the result appears 1 cycle later. With MUL_ARB_STATS_EN, STALLS does not count the EN=0 cycles.

Source files
------------

// File: rtl/mul_arb_pkg.sv
// Shared helpers for the time-shared multiplier arbiter:
// tag-width helper, stats counter width, saturating increment.
package mul_arb_pkg;

  localparam int CNT_W = 16;

  function automatic int idw_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             inc
  );
    if (inc && (v != '1)) return v + CNT_W'(1);
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit from ptr_i upward.
// Ports: req_i/ptr_i/en_i in; one-hot gnt_o, index idx_o, any_o out.
module rr_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = idw_f(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  always_comb begin
    int            jj;
    logic [IDW-1:0] j;
    logic          found;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    found = 1'b0;
    jj    = 0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      jj = int'(ptr_i) + k;
      if (jj >= NREQ) jj = jj - NREQ;
      j = IDW'(jj);
      if (en_i && !found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// One registered NxN multiplier shared round-robin by NREQ requesters.
// Ports: CLK, RST(sync high), EN, R_IN1/2, D_IN1/2 in; ACK, R_OUT,
// D_OUT, BUSY out. MUL_ARB_STATS_EN adds GRANTS and STALLS counters.
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int N    = 16,
  parameter int NREQ = 4,
  parameter int IDW  = idw_f(NREQ)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [NREQ-1:0]   R_IN1,
  input  logic [NREQ*N-1:0] D_IN1,
  input  logic [NREQ-1:0]   R_IN2,
  input  logic [NREQ*N-1:0] D_IN2,
  output logic [NREQ-1:0]   ACK,
  output logic [NREQ-1:0]   R_OUT,
  output logic [NREQ*N-1:0] D_OUT,
  output logic              BUSY
`ifdef MUL_ARB_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0] GRANTS,
  output logic [CNT_W-1:0]      STALLS
`endif
);

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gidx;
  logic            gany;

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           s1_v_q;
  logic [N-1:0]   s1_a_q, s1_b_q;
  logic [IDW-1:0] s1_id_q;
  logic           s2_v_q;
  logic [IDW-1:0] s2_id_q;
  logic [NREQ-1:0][N-1:0] dout_q;

  logic [2*N-1:0] full_p;
  logic [N-1:0]   s2_p_d;

  assign elig = R_IN1 & R_IN2;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i (elig),
    .ptr_i (ptr_q),
    .en_i  (EN & ~RST),
    .gnt_o (gnt),
    .idx_o (gidx),
    .any_o (gany)
  );

  assign ACK = gnt;

  always_comb begin
    ptr_d = ptr_q;
    if (gany) begin
      ptr_d = (gidx == IDW'(NREQ-1)) ? '0 : gidx + IDW'(1);
    end
  end

  assign full_p = s1_a_q * s1_b_q;
  assign s2_p_d = (s1_b_q == '0) ? '0 : full_p[N-1:0];

  // The result slot is written on the same edge that loads stage 2,
  // so D_OUT already carries the product while R_OUT pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q   <= '0;
      s1_v_q  <= 1'b0;
      s1_a_q  <= '0;
      s1_b_q  <= '0;
      s1_id_q <= '0;
      s2_v_q  <= 1'b0;
      s2_id_q <= '0;
      dout_q  <= '0;
    end else if (EN) begin
      ptr_q   <= ptr_d;
      s1_v_q  <= gany;
      s1_a_q  <= D_IN1[gidx*N +: N];
      s1_b_q  <= D_IN2[gidx*N +: N];
      s1_id_q <= gidx;
      s2_v_q  <= s1_v_q;
      s2_id_q <= s1_id_q;
      if (s1_v_q) dout_q[s1_id_q] <= s2_p_d;
    end
  end

  always_comb begin
    R_OUT = '0;
    if (s2_v_q) R_OUT[s2_id_q] = 1'b1;
  end

  assign D_OUT = dout_q;
  assign BUSY  = s1_v_q | s2_v_q;

`ifdef MUL_ARB_STATS_EN
  logic [NREQ-1:0][CNT_W-1:0] grants_q;
  logic [CNT_W-1:0]           stalls_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      grants_q <= '0;
      stalls_q <= '0;
    end else if (EN) begin
      for (int i = 0; i < NREQ; i++) begin
        grants_q[i] <= sat_inc(grants_q[i], gnt[i]);
      end
      stalls_q <= sat_inc(stalls_q, |(elig & ~gnt));
    end
  end

  assign GRANTS = grants_q;
  assign STALLS = stalls_q;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter (N=16, NREQ=4).
// Inputs change after the falling edge; outputs are checked 1ns later.
module tb_mul_share_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN;
  logic [3:0]  R1, R2;
  logic [63:0] D1, D2;
  logic [3:0]  ACK, ROUT;
  logic [63:0] DOUT;
  logic        BUSY;
`ifdef MUL_ARB_STATS_EN
  logic [63:0] GRANTS;
  logic [15:0] STALLS;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  mul_share_arbiter #(
    .N    (16),
    .NREQ (4)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .EN    (EN),
    .R_IN1 (R1),
    .D_IN1 (D1),
    .R_IN2 (R2),
    .D_IN2 (D2),
    .ACK   (ACK),
    .R_OUT (ROUT),
    .D_OUT (DOUT),
    .BUSY  (BUSY)
`ifdef MUL_ARB_STATS_EN
    ,
    .GRANTS (GRANTS),
    .STALLS (STALLS)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setd(input int i, input logic [15:0] a,
                      input logic [15:0] b);
    D1[i*16 +: 16] = a;
    D2[i*16 +: 16] = b;
  endtask

  task automatic step(input logic [3:0] r1, input logic [3:0] r2);
    @(negedge CLK);
    R1 = r1;
    R2 = r2;
    #1;
  endtask

  function automatic logic [15:0] slot(input int i);
    return DOUT[i*16 +: 16];
  endfunction

  initial begin
    RST = 1'b1;
    EN  = 1'b1;
    R1  = '0;
    R2  = '0;
    D1  = '0;
    D2  = '0;

    // reset state; ACK suppressed while RST
    step(4'hF, 4'hF);
    chk("rst_ack", 64'(ACK), 0);
    chk("rst_rout", 64'(ROUT), 0);
    chk("rst_dout", DOUT, 0);
    chk("rst_busy", 64'(BUSY), 0);
    step(4'h0, 4'h0);
    RST = 1'b0;

    // single requester 2: 7*9
    setd(2, 16'd7, 16'd9);
    step(4'h4, 4'h4);
    chk("single_ack", 64'(ACK), 64'h4);
    step(4'h0, 4'h0);
    chk("single_ack_off", 64'(ACK), 0);
    chk("single_busy1", 64'(BUSY), 1);
    chk("single_rout_early", 64'(ROUT), 0);
    step(4'h0, 4'h0);
    chk("single_rout", 64'(ROUT), 64'h4);
    chk("single_dout", DOUT, 64'h0000_003F_0000_0000);
    chk("single_busy2", 64'(BUSY), 1);
    step(4'h0, 4'h0);
    chk("single_rout_end", 64'(ROUT), 0);
    chk("single_busy_end", 64'(BUSY), 0);
    chk("single_hold", 64'(slot(2)), 63);

    // PTR=3: requesters 3 and 0 eligible -> 3 then 0
    setd(3, 16'hFFFF, 16'd2);
    setd(0, 16'd3, 16'd5);
    step(4'h9, 4'h9);
    chk("wrap_ack3", 64'(ACK), 64'h8);
    step(4'h1, 4'h1);
    chk("wrap_ack0", 64'(ACK), 64'h1);
    step(4'h0, 4'h0);
    chk("wrap_rout3", 64'(ROUT), 64'h8);
    chk("trunc_dout", 64'(slot(3)), 64'hFFFE);
    step(4'h0, 4'h0);
    chk("wrap_rout0", 64'(ROUT), 64'h1);
    chk("wrap_dout0", 64'(slot(0)), 15);
    step(4'h0, 4'h0);
    chk("wrap_idle", 64'(ROUT), 0);

    // PTR=1: requester 1 partial, requester 3 with zero operand
    setd(3, 16'h1234, 16'h0000);
    step(4'hA, 4'h8);
    chk("part_ack3", 64'(ACK), 64'h8);
    step(4'h2, 4'h0);
    chk("part_noack1", 64'(ACK), 0);
    step(4'h2, 4'h0);
    chk("part_noack2", 64'(ACK), 0);
    chk("zero_rout", 64'(ROUT), 64'h8);
    chk("zero_dout", 64'(slot(3)), 0);
    step(4'h0, 4'h0);

    // full contention from PTR=0
    for (int i = 0; i < 4; i++) setd(i, 16'(i + 2), 16'd10);
    for (int k = 0; k < 7; k++) begin
      logic [3:0]  ea;
      logic [3:0]  er;
      logic [15:0] ev;
      int          j;
      step((k < 5) ? 4'hF : 4'h0, (k < 5) ? 4'hF : 4'h0);
      if (k == 1) setd(0, 16'd9, 16'd10);
      ea = (k < 5) ? 4'(1 << (k % 4)) : 4'h0;
      chk($sformatf("cont_ack%0d", k), 64'(ACK), 64'(ea));
      if (k >= 2) begin
        j  = (k - 2) % 4;
        er = 4'(1 << j);
        ev = (k == 6) ? 16'd90 : 16'((j + 2) * 10);
        chk($sformatf("cont_rout%0d", k), 64'(ROUT), 64'(er));
        chk($sformatf("cont_dout%0d", k), 64'(slot(j)), 64'(ev));
      end
    end
    step(4'h0, 4'h0);
    chk("cont_idle", 64'(ROUT), 0);

    // EN stall with stage 1 occupied (PTR=1)
    setd(1, 16'd100, 16'd3);
    step(4'h2, 4'h2);
    chk("stall_ack", 64'(ACK), 64'h2);
    for (int k = 0; k < 3; k++) begin
      step(4'h4, 4'h4);
      EN = 1'b0;
      #1;
      chk($sformatf("stall_noack%0d", k), 64'(ACK), 0);
      chk($sformatf("stall_busy%0d", k), 64'(BUSY), 1);
      chk($sformatf("stall_rout%0d", k), 64'(ROUT), 0);
    end
    step(4'h0, 4'h0);
    EN = 1'b1;
    #1;
    chk("resume_rout0", 64'(ROUT), 0);
    step(4'h0, 4'h0);
    chk("resume_rout", 64'(ROUT), 64'h2);
    chk("resume_dout", 64'(slot(1)), 300);
    EN = 1'b0;
    step(4'h0, 4'h0);
    chk("hold_rout1", 64'(ROUT), 64'h2);
    step(4'h0, 4'h0);
    chk("hold_rout2", 64'(ROUT), 64'h2);
    EN = 1'b1;
    step(4'h0, 4'h0);
    chk("hold_release", 64'(ROUT), 0);
    chk("hold_busy", 64'(BUSY), 0);

    // reset mid-flight (PTR=2, only requester 0 eligible)
    setd(0, 16'd5, 16'd5);
    step(4'h1, 4'h1);
    chk("mid_ack", 64'(ACK), 64'h1);
    step(4'hF, 4'hF);
    RST = 1'b1;
    #1;
    chk("mid_rst_ack", 64'(ACK), 0);
    step(4'h0, 4'h0);
    RST = 1'b0;
    #1;
    chk("mid_rout", 64'(ROUT), 0);
    chk("mid_busy", 64'(BUSY), 0);
    chk("mid_dout", DOUT, 0);
    step(4'hF, 4'hF);
    chk("mid_ptr0", 64'(ACK), 64'h1);
    step(4'h0, 4'h0);
    chk("mid_rout_gap", 64'(ROUT), 0);
    step(4'h0, 4'h0);
    chk("mid_rout_new", 64'(ROUT), 64'h1);
    chk("mid_dout_new", 64'(slot(0)), 25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
